toggle_event_sender: RTL

- Transmit end of the team's toggle-based event crossing.
- Converts single-cycle event pulses in the `clk` domain into edges on a level signal, `toggle_out`. Each edge marks one event.
- `toggle_out` feeds a toggle-synchronizer receiver in another clock domain.
- Guarantees a minimum spacing between edges so a slower receiver sees every edge. Events arriving faster than that spacing are queued in a saturating pending counter, not merged.

---
 rtl/toggle_event_pkg.sv | 18 +
 rtl/toggle_gap_timer.sv | 27 ++
 rtl/toggle_event_sender.sv | 101 ++++++++++
 3 files changed

// File: rtl/toggle_event_pkg.sv
// Shared types and helpers for the toggle-based event sender.
package toggle_event_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam int DROP_CNT_W = 16;

    // A gap of 1 or 2 still needs a 1-bit timer so the port is never zero-width.
    function automatic int timer_width(input int min_gap);
        int w;
        w = $clog2(min_gap);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/toggle_gap_timer.sv
// Load/decrement down-counter enforcing the minimum spacing between toggle edges.
module toggle_gap_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/toggle_event_sender.sv
// Converts clk-domain event pulses into spaced edges on toggle_out, queueing bursts in a saturating counter.
// Optional drop_count output is enabled by defining TOGGLE_EVENT_SENDER_DROP_CNT_EN.
module toggle_event_sender
    import toggle_event_pkg::*;
#(
    parameter int MIN_GAP = 4,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_pulse,
    output logic             toggle_out,
    output logic [CNT_W-1:0] pending,
    output logic             busy,
    output logic             overflow
`ifdef TOGGLE_EVENT_SENDER_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_count
`endif
);

    localparam int               TIMER_W  = timer_width(MIN_GAP);
    localparam logic [TIMER_W-1:0] GAP_LOAD = TIMER_W'(MIN_GAP - 1);
    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    logic             r_toggle;
    logic [CNT_W-1:0] r_pending;
    logic             r_overflow;

    logic             w_timer_zero;
    state_e           w_state;
    logic             w_pend_nz;
    logic             w_req;
    logic             w_fire;
    logic             w_drop;
    logic [CNT_W-1:0] w_pending_nxt;

    toggle_gap_timer #(
        .W(TIMER_W)
    ) u_gap_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_fire),
        .i_load_val (GAP_LOAD),
        .o_zero     (w_timer_zero)
    );

    // The FSM state is a pure decode of the gap timer: IDLE exactly when it has run out.
    assign w_state   = w_timer_zero ? IDLE : HOLD;
    assign w_pend_nz = (r_pending != '0);
    assign w_req     = in_pulse | w_pend_nz;
    assign w_fire    = (w_state == IDLE) & w_req;
    assign w_drop    = in_pulse & ~w_fire & (r_pending == PEND_MAX);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_fire) begin
            // Firing from the queue while a new pulse arrives is a net-zero swap.
            if (w_pend_nz && !in_pulse) begin
                w_pending_nxt = r_pending - CNT_W'(1);
            end
        end else if (in_pulse && !w_drop) begin
            w_pending_nxt = r_pending + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_toggle   <= 1'b0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_fire) begin
                r_toggle <= ~r_toggle;
            end
            r_pending  <= w_pending_nxt;
            r_overflow <= w_drop;
        end
    end

`ifdef TOGGLE_EVENT_SENDER_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
        end
    end

    assign drop_count = r_drop_cnt;
`endif

    assign toggle_out = r_toggle;
    assign pending    = r_pending;
    assign busy       = (w_state == HOLD) | w_pend_nz;
    assign overflow   = r_overflow;

endmodule
